// File: rtl/ecg_codec_pkg.sv
// ecg_codec_pkg
// Shared definitions for the ECG entropy decoder: the decoder FSM state
// enumeration, the maximum encoded group length, the number of samples per
// group and the widths of the size field and the bits-required value.
package ecg_codec_pkg;

    localparam int ECG_MAX_BITS    = 50;
    localparam int SAMPLES_PER_ECG = 4;
    localparam int ECG_SIZE_W      = 6;
    localparam int ECG_K_W         = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLAG,
        ST_PREFIX,
        ST_SAMPLE,
        ST_DONE
    } ecg_state_t;

endpackage

// File: rtl/ecg_sample_assembler.sv
// ecg_sample_assembler
// Collects the sample field of an ECG group one bit at a time into four
// accumulators (sample_1 first, MSB first) and presents each accumulator
// sign-extended from k bits to DATA_WIDTH bits.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   i_clear          zero all accumulators and restart at sample_1
//   i_shift_en       shift i_bit into the current sample this cycle
//   i_bit            the bitstream bit being consumed
//   i_k              bits per sample (0..DATA_WIDTH)
//   o_last           this shift completes the fourth sample
//   o_sample_1..4    sign-extended samples
module ecg_sample_assembler
    import ecg_codec_pkg::*;
#(
    parameter int DATA_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clear,
    input  logic                         i_shift_en,
    input  logic                         i_bit,
    input  logic [ECG_K_W-1:0]           i_k,
    output logic                         o_last,
    output logic signed [DATA_WIDTH-1:0] o_sample_1,
    output logic signed [DATA_WIDTH-1:0] o_sample_2,
    output logic signed [DATA_WIDTH-1:0] o_sample_3,
    output logic signed [DATA_WIDTH-1:0] o_sample_4
);

    logic [DATA_WIDTH-1:0] r_acc [SAMPLES_PER_ECG];
    logic [1:0]            r_idx;
    logic [ECG_K_W-1:0]    r_bit_cnt;
    logic                  w_sample_end;

    // Shift the k-bit field to the top, then arithmetic-shift back down so
    // bit k-1 becomes the sign. k==0 yields zero.
    function automatic logic signed [DATA_WIDTH-1:0] sign_extend(
        input logic [DATA_WIDTH-1:0] raw,
        input logic [ECG_K_W-1:0]    k
    );
        logic signed [DATA_WIDTH-1:0] tmp;
        int                           sh;
        if (k == '0) begin
            return '0;
        end
        sh  = DATA_WIDTH - int'(k);
        tmp = raw << sh;
        return tmp >>> sh;
    endfunction

    // i_k is at least 1 whenever shifting is enabled.
    assign w_sample_end = (r_bit_cnt == i_k - 1'b1);
    assign o_last       = i_shift_en && w_sample_end && (r_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SAMPLES_PER_ECG; i++) begin
                r_acc[i] <= '0;
            end
            r_idx     <= '0;
            r_bit_cnt <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < SAMPLES_PER_ECG; i++) begin
                r_acc[i] <= '0;
            end
            r_idx     <= '0;
            r_bit_cnt <= '0;
        end else if (i_shift_en) begin
            r_acc[r_idx] <= {r_acc[r_idx][DATA_WIDTH-2:0], i_bit};
            if (w_sample_end) begin
                r_bit_cnt <= '0;
                r_idx     <= r_idx + 2'd1;
            end else begin
                r_bit_cnt <= r_bit_cnt + 1'b1;
            end
        end
    end

    assign o_sample_1 = sign_extend(r_acc[0], i_k);
    assign o_sample_2 = sign_extend(r_acc[1], i_k);
    assign o_sample_3 = sign_extend(r_acc[2], i_k);
    assign o_sample_4 = sign_extend(r_acc[3], i_k);

endmodule

// File: rtl/ecg_entropy_decoder.sv
// ecg_entropy_decoder
// Decodes one MSB-aligned ECG group per handshake, one bit per clock:
// skip flag, unary k prefix (terminator omitted when k==DATA_WIDTH), then
// four k-bit two's complement samples. Holds the result until out_ready.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready        input handshake (in_ready high only in IDLE)
//   encoded_ECG[49:0]          encoded group, bit 49 decoded first
//   sizeof_encoded_ECG[5:0]    number of valid bits L
//   out_valid / out_ready      output handshake
//   sample_1..sample_4         decoded residuals, signed DATA_WIDTH
//   bits_req[3:0]              decoded k
//   decode_err                 group malformed (qualified by out_valid)
module ecg_entropy_decoder
    import ecg_codec_pkg::*;
#(
    parameter int DATA_WIDTH = 10
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ECG_MAX_BITS-1:0]      encoded_ECG,
    input  logic [ECG_SIZE_W-1:0]        sizeof_encoded_ECG,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] sample_1,
    output logic signed [DATA_WIDTH-1:0] sample_2,
    output logic signed [DATA_WIDTH-1:0] sample_3,
    output logic signed [DATA_WIDTH-1:0] sample_4,
    output logic [ECG_K_W-1:0]           bits_req,
    output logic                         decode_err
);

    localparam logic [ECG_K_W-1:0]    K_MAX    = ECG_K_W'(DATA_WIDTH);
    localparam logic [ECG_SIZE_W-1:0] SIZE_MAX = ECG_SIZE_W'(ECG_MAX_BITS);

    ecg_state_t              r_state;
    logic [ECG_MAX_BITS-1:0] r_shift;
    logic [ECG_SIZE_W-1:0]   r_cnt;
    logic [ECG_SIZE_W-1:0]   r_len;
    logic [ECG_K_W-1:0]      r_k;
    logic                    r_in_ready;
    logic                    r_out_valid;
    logic                    r_err;

    logic                    w_accept;
    logic                    w_bit;
    logic                    w_have_bit;
    logic [ECG_SIZE_W-1:0]   w_cnt_next;
    logic                    w_trailing;
    logic                    w_shift_en;
    logic                    w_clear;
    logic                    w_last;

    // r_in_ready is only ever set while in IDLE.
    assign w_accept   = r_in_ready && in_valid;
    assign w_bit      = r_shift[ECG_MAX_BITS-1];
    // Consuming another bit is legal only while fewer than L bits are used.
    assign w_have_bit = (r_cnt < r_len);
    assign w_cnt_next = r_cnt + 1'b1;
    // Completing with fewer bits consumed than L leaves trailing bits.
    assign w_trailing = (w_cnt_next < r_len);
    assign w_shift_en = (r_state == ST_SAMPLE) && w_have_bit;
    // Samples restart on accept and are zeroed when a sample field truncates.
    assign w_clear    = w_accept || ((r_state == ST_SAMPLE) && !w_have_bit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_shift     <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_k         <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_in_ready <= 1'b0;
                        r_shift    <= encoded_ECG;
                        r_len      <= sizeof_encoded_ECG;
                        r_cnt      <= '0;
                        r_k        <= '0;
                        if (sizeof_encoded_ECG == '0 || sizeof_encoded_ECG > SIZE_MAX) begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b1;
                            r_err       <= 1'b1;
                        end else begin
                            r_state <= ST_FLAG;
                            r_err   <= 1'b0;
                        end
                    end else begin
                        r_in_ready <= 1'b1;
                    end
                end
                ST_FLAG, ST_PREFIX, ST_SAMPLE: begin
                    if (!w_have_bit) begin
                        // Stream truncated: report with zeroed samples.
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
                        r_err       <= 1'b1;
                    end else begin
                        r_shift <= {r_shift[ECG_MAX_BITS-2:0], 1'b0};
                        r_cnt   <= w_cnt_next;
                        case (r_state)
                            ST_FLAG: begin
                                if (w_bit) begin
                                    r_state     <= ST_DONE;
                                    r_out_valid <= 1'b1;
                                    r_err       <= w_trailing;
                                end else begin
                                    r_state <= ST_PREFIX;
                                end
                            end
                            ST_PREFIX: begin
                                if (w_bit) begin
                                    r_k <= r_k + 1'b1;
                                    // No terminator follows k == DATA_WIDTH.
                                    if (r_k == K_MAX - 1'b1) begin
                                        r_state <= ST_SAMPLE;
                                    end
                                end else if (r_k == '0) begin
                                    r_state     <= ST_DONE;
                                    r_out_valid <= 1'b1;
                                    r_err       <= w_trailing;
                                end else begin
                                    r_state <= ST_SAMPLE;
                                end
                            end
                            default: begin
                                if (w_last) begin
                                    r_state     <= ST_DONE;
                                    r_out_valid <= 1'b1;
                                    r_err       <= w_trailing;
                                end
                            end
                        endcase
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    ecg_sample_assembler #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_assembler (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_clear),
        .i_shift_en (w_shift_en),
        .i_bit      (w_bit),
        .i_k        (r_k),
        .o_last     (w_last),
        .o_sample_1 (sample_1),
        .o_sample_2 (sample_2),
        .o_sample_3 (sample_3),
        .o_sample_4 (sample_4)
    );

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign bits_req   = r_k;
    assign decode_err = r_err;

endmodule

// File: tb/tb_ecg_entropy_decoder.sv
// tb_ecg_entropy_decoder
// Self-checking bench for ecg_entropy_decoder (DATA_WIDTH=10). Expected
// results come from a bit-pointer parser of the group format.
module tb_ecg_entropy_decoder;

    localparam int W = 10;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic                out_ready = 1'b0;
    logic [49:0]         encoded_ECG = '0;
    logic [5:0]          sizeof_encoded_ECG = '0;
    logic                in_ready;
    logic                out_valid;
    logic                decode_err;
    logic [3:0]          bits_req;
    logic signed [W-1:0] sample_1, sample_2, sample_3, sample_4;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [4*W-1:0] s;
        logic [3:0]     k;
        logic           err;
        int             lat;
    } exp_t;

    always #5 clk = ~clk;

    ecg_entropy_decoder #(.DATA_WIDTH(W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .encoded_ECG        (encoded_ECG),
        .sizeof_encoded_ECG (sizeof_encoded_ECG),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .sample_1           (sample_1),
        .sample_2           (sample_2),
        .sample_3           (sample_3),
        .sample_4           (sample_4),
        .bits_req           (bits_req),
        .decode_err         (decode_err)
    );

    // Build an MSB-aligned group; n is its full length (may exceed 50).
    function automatic void encode(input bit flag, input int k, input int v0, input int v1,
                                   input int v2, input int v3,
                                   output logic [49:0] w, output int n);
        int vals [4];
        vals = '{v0, v1, v2, v3};
        w = '0;
        w[49] = flag;
        n = 1;
        if (flag) return;
        for (int i = 0; i < k; i++) begin
            if (n < 50) w[49-n] = 1'b1;
            n++;
        end
        if (k < W) begin
            if (n < 50) w[49-n] = 1'b0;
            n++;
        end
        for (int s = 0; s < 4; s++) begin
            for (int b = k - 1; b >= 0; b--) begin
                if (n < 50) w[49-n] = ((vals[s] >> b) & 1) != 0;
                n++;
            end
        end
    endfunction

    // Reference parser: walks the word with a bit pointer limited to L bits.
    function automatic exp_t model(input logic [49:0] w, input int L);
        exp_t e;
        int   pos;
        int   k;
        int   v;
        e.s = '0; e.k = '0; e.err = 1'b0; e.lat = 0;
        if (L == 0 || L > 50) begin
            e.err = 1'b1;
            return e;
        end
        if (w[49]) begin
            e.lat = 1;
            e.err = (L > 1);
            return e;
        end
        pos = 1;
        k = 0;
        while (k < W) begin
            if (pos >= L) begin
                e.err = 1'b1; e.k = 4'(k); e.lat = L + 1;
                return e;
            end
            pos++;
            if (w[50-pos]) k++;
            else break;
        end
        e.k = 4'(k);
        if (k > 0) begin
            for (int i = 0; i < 4; i++) begin
                v = 0;
                for (int j = 0; j < k; j++) begin
                    if (pos >= L) begin
                        e.s = '0; e.err = 1'b1; e.lat = L + 1;
                        return e;
                    end
                    v = v * 2 + int'(w[49-pos]);
                    pos++;
                end
                if (v >= (1 << (k - 1))) v -= (1 << k);
                e.s[(3-i)*W +: W] = W'(v);
            end
        end
        e.lat = pos;
        e.err = (pos < L);
        return e;
    endfunction

    task automatic send(input logic [49:0] w, input int L);
        int t = 0;
        @(negedge clk);
        while (in_ready !== 1'b1 && t < 60) begin
            @(negedge clk);
            t++;
        end
        if (in_ready !== 1'b1) begin
            n_cmp++; n_fail++;
            $display("FAIL send_in_ready: in_ready=%b required 1", in_ready);
        end
        encoded_ECG = w;
        sizeof_encoded_ECG = 6'(L);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int cyc);
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 80) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic release_out(input int hold);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if ({out_valid, decode_err, bits_req, sample_1, sample_2, sample_3, sample_4, in_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ov=%b err=%b k=%0d s=%0d,%0d,%0d,%0d rdy=%b required all 0",
                     out_valid, decode_err, bits_req, sample_1, sample_2, sample_3, sample_4, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready_before_edge: in_ready=%b required 0", in_ready);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready_after_edge: in_ready=%b required 1", in_ready);
        end
    endtask

    task automatic test_directed();
        logic [49:0] w [9];
        int          L [9];
        int          n;
        int          cyc;
        exp_t        e;
        encode(0, 3, 3, -2, 0, -4, w[0], n);     L[0] = n;       // normal, 17 bits
        w[1] = 50'h0; w[1][49] = 1'b1;           L[1] = 1;       // skip
        encode(0, 10, 511, -512, 1, -1, w[2], n); L[2] = n;      // k=10, L=51
        encode(0, 9, 255, -256, 1, -1, w[3], n); L[3] = n;       // k=9 fits
        encode(0, 3, 3, -2, 0, -4, w[4], n);     L[4] = 10;      // truncated
        encode(0, 3, 3, -2, 0, -4, w[5], n);     L[5] = 20;      // trailing bits
        encode(0, 0, 0, 0, 0, 0, w[6], n);       L[6] = n;       // k==0
        w[7] = w[0];                             L[7] = 0;       // size zero
        w[8] = w[1];                             L[8] = 5;       // skip + trailing
        for (int i = 0; i < 9; i++) begin
            e = model(w[i], L[i]);
            send(w[i], L[i]);
            wait_out(cyc);
            n_cmp++;
            if (cyc !== e.lat) begin
                n_fail++;
                $display("FAIL dir%0d_latency: got %0d edges required %0d", i, cyc, e.lat);
            end
            n_cmp++;
            if ({sample_1, sample_2, sample_3, sample_4} !== e.s) begin
                n_fail++;
                $display("FAIL dir%0d_samples: got %0d,%0d,%0d,%0d required %h", i,
                         sample_1, sample_2, sample_3, sample_4, e.s);
            end
            n_cmp++;
            if (bits_req !== e.k) begin
                n_fail++;
                $display("FAIL dir%0d_bits_req: got %0d required %0d", i, bits_req, e.k);
            end
            n_cmp++;
            if (decode_err !== e.err) begin
                n_fail++;
                $display("FAIL dir%0d_decode_err: got %b required %b", i, decode_err, e.err);
            end
            release_out(0);
            n_cmp++;
            if ({out_valid, in_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL dir%0d_handshake: ov=%b rdy=%b required 0,1", i, out_valid, in_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [49:0]    w;
        logic [49:0]    skip_w;
        int             n;
        int             cyc;
        logic [4*W-1:0] snap;
        logic [4:0]     snap_kerr;
        encode(0, 3, 3, -2, 0, -4, w, n);
        skip_w = '0; skip_w[49] = 1'b1;
        send(w, n);
        wait_out(cyc);
        snap = {sample_1, sample_2, sample_3, sample_4};
        snap_kerr = {bits_req, decode_err};
        n_cmp++;
        if (snap !== {10'sd3, -10'sd2, 10'sd0, -10'sd4}) begin
            n_fail++;
            $display("FAIL bp_first_samples: got %h required 3,-2,0,-4", snap);
        end
        @(negedge clk);
        encoded_ECG = skip_w; sizeof_encoded_ECG = 6'd1; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({out_valid, in_ready} !== 2'b10 || {sample_1, sample_2, sample_3, sample_4} !== snap
                || {bits_req, decode_err} !== snap_kerr) begin
                n_fail++;
                $display("FAIL bp_hold%0d: ov=%b rdy=%b s=%0d,%0d,%0d,%0d k=%0d err=%b required held",
                         c, out_valid, in_ready, sample_1, sample_2, sample_3, sample_4, bits_req, decode_err);
            end
        end
        in_valid = 1'b0;
        release_out(0);
        n_cmp++;
        if ({out_valid, in_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL bp_release: ov=%b rdy=%b required 0,1", out_valid, in_ready);
        end
        send(skip_w, 1);
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_second_accept: in_ready=%b required 0", in_ready);
        end
        wait_out(cyc);
        n_cmp++;
        if (cyc !== 1 || {sample_1, sample_2, sample_3, sample_4, bits_req, decode_err} !== '0) begin
            n_fail++;
            $display("FAIL bp_second_result: lat=%0d k=%0d err=%b required lat 1, all 0",
                     cyc, bits_req, decode_err);
        end
        release_out(0);
    endtask

    task automatic test_reset_mid_decode();
        logic [49:0] w;
        int          n;
        int          cyc;
        int          seen;
        encode(0, 3, 3, -2, 0, -4, w, n);
        send(w, n);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, decode_err, bits_req, sample_1, sample_2, sample_3, sample_4, in_ready} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outputs: ov=%b err=%b k=%0d s=%0d,%0d,%0d,%0d rdy=%b required all 0",
                     out_valid, decode_err, bits_req, sample_1, sample_2, sample_3, sample_4, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL midrst_no_valid: out_valid high %0d cycles required 0", seen);
        end
        send(w, n);
        wait_out(cyc);
        n_cmp++;
        if (cyc !== 17 || {sample_1, sample_2, sample_3, sample_4} !== {10'sd3, -10'sd2, 10'sd0, -10'sd4}
            || bits_req !== 4'd3 || decode_err !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_next: lat=%0d s=%0d,%0d,%0d,%0d k=%0d err=%b required 17,3,-2,0,-4,3,0",
                     cyc, sample_1, sample_2, sample_3, sample_4, bits_req, decode_err);
        end
        release_out(0);
    endtask

    task automatic test_random_groups();
        logic [49:0] w;
        int          n;
        int          L;
        int          k;
        int          mode;
        int          cyc;
        bit          flag;
        int          v [4];
        exp_t        e;
        for (int it = 0; it < 40; it++) begin
            flag = ($urandom_range(0, 7) == 0);
            k = $urandom_range(0, W);
            for (int s = 0; s < 4; s++) v[s] = (k == 0) ? 0 : int'($urandom_range(0, (1 << k) - 1));
            encode(flag, k, v[0], v[1], v[2], v[3], w, n);
            mode = $urandom_range(0, 9);
            if (mode <= 5)      L = n;
            else if (mode <= 7) L = (n + int'($urandom_range(1, 4)) > 50) ? 50 : n + int'($urandom_range(1, 4));
            else if (mode == 8) L = (n > 1) ? n - int'($urandom_range(1, n - 1)) : n;
            else                L = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(51, 63));
            e = model(w, L);
            send(w, L);
            wait_out(cyc);
            n_cmp++;
            if (cyc !== e.lat || {sample_1, sample_2, sample_3, sample_4} !== e.s
                || bits_req !== e.k || decode_err !== e.err) begin
                n_fail++;
                $display("FAIL rand%0d: L=%0d lat=%0d s=%h k=%0d err=%b required lat=%0d s=%h k=%0d err=%b",
                         it, L, cyc, {sample_1, sample_2, sample_3, sample_4}, bits_req, decode_err,
                         e.lat, e.s, e.k, e.err);
            end
            release_out($urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_decode();
        test_random_groups();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
